multdiv_controller: RTL
=======================

// Module: multdiv_controller
// PURPOSE
//  Sequences the multi-cycle multiplier/divider for the 5-stage pipeline. It detects mul/div
//  in the execute (DX) stage, issues a one-cycle start pulse and holds the operands stable.
//  It stalls PC/FD/DX until the unit reports ready (or times out), then presents the result
//  for one cycle so it can be muxed into the XM ALU-output path.
// PARAMETERS
//  WIDTH       32  datapath width of operands/result
//  MAX_CYCLES  40  WAIT cycles before timeout is declared (>=2)
//  CNT_W       6   wait-counter width; must satisfy 2**CNT_W > MAX_CYCLES
// PORTS
//  clock          in   1      master clock; FSM/registers update on rising edge
//  reset          in   1      asynchronous, active-high
//  dx_ir          in   32     instruction currently in DX
//  dx_A           in   WIDTH  DX operand A ($rs)
//  dx_B           in   WIDTH  DX operand B ($rt)
//  md_result      in   WIDTH  multdiv result
//  md_exception   in   1      multdiv exception (overflow / divide-by-zero)
//  md_resultRDY   in   1      multdiv result-ready strobe
//  md_ctrl_mult   out  1      one-cycle start pulse, multiply
//  md_ctrl_div    out  1      one-cycle start pulse, divide
//  md_operandA    out  WIDTH  operand A to multdiv, stable from pulse until DONE
//  md_operandB    out  WIDTH  operand B to multdiv, stable from pulse until DONE
//  stall          out  1      freeze PC, FD and DX; inject bubble into XM
//  busy           out  1      FSM not in IDLE
//  result_valid   out  1      one-cycle: result/exception valid, XM takes them
//  result         out  WIDTH  latched multdiv result (0 on timeout)
//  exception      out  1      latched md_exception, or 1 on timeout
// BEHAVIOUR
//  Decode: is_md = opcode dx_ir[31:27]==00000 and ALUop dx_ir[6:2] in {00110 mul, 00111 div}.
//   All other opcodes never start an operation, whatever their low bits hold.
//  Reset (async): state=IDLE, count=0. Every output is 0, the held operands are 0, and the
//   result/exception registers are 0.
//  FSM states: IDLE, WAIT, DONE.
//   IDLE: if is_md (combinational), then stall=1 and md_ctrl_mult/md_ctrl_div=1 for this cycle
//     only. md_operandA/B drive dx_A/dx_B straight through. On the rising edge, latch
//     dx_A/dx_B into the hold registers, set count=0, and go to WAIT. If not is_md, stay in
//     IDLE with stall=0. md_resultRDY is ignored in IDLE.
//   WAIT: stall=1, busy=1, md_operandA/B come from the hold registers, count increments.
//     If md_resultRDY: latch md_result/md_exception and go to DONE.
//     Else if count==MAX_CYCLES-1: latch result=0, exception=1, and go to DONE (timeout).
//     If RDY and timeout coincide, RDY wins.
//   DONE: stall=0, busy=1, result_valid=1, and result/exception are driven. DX advances on
//     this cycle. Go to IDLE unconditionally, without sampling dx_ir. As a result, a following
//     mul/div is detected in the next IDLE cycle as a fresh operation.
//  Start pulses are never asserted outside IDLE, and never both in the same cycle.
//  Latency: pulse at cycle 0, RDY seen in WAIT at cycle N gives result_valid at cycle N+1.
//   stall is high in cycles 0..N.
//  result/exception hold their last latched value after DONE until the next latch. Consumers
//   use them only when result_valid is high.
//  Reset mid-operation (WAIT or DONE): return to IDLE at once and drop stall. A late
//   md_resultRDY is ignored. The multdiv unit is restarted by the next pulse.
// TESTING
//  1 mul: dx_A=6, dx_B=7, RDY after 17 WAIT cycles -> single md_ctrl_mult pulse, stall high
//    18 cycles, then one result_valid cycle with result=42 and exception=0.
//  2 div 100/0, model raises exception with RDY -> result_valid=1 and exception=1; md_ctrl_div
//    pulsed exactly once; md_ctrl_mult never.
//  3 mul(3*4) directly followed by div(20/5) -> two separate pulses; result_valid shows 12,
//    then 4 after the second wait; stall low only during DONE and the IDLE-to-IDLE gap rules.
//  4 timeout: RDY never asserted -> after MAX_CYCLES WAIT cycles, result_valid with result=0
//    and exception=1; FSM back in IDLE next cycle.
//  5 reset pulsed in the 5th WAIT cycle -> all outputs 0 immediately (asynchronously); a later
//    RDY produces no result_valid.
//  6 add (ALUop 00000) and addi (opcode 00101 with dx_ir[6:2]=00110) in DX -> no stall and
//    no start pulse.

Source files
------------

// File: rtl/multdiv_controller.sv
// Sequencer for the multi-cycle multiplier/divider: detects mul/div in DX, pulses the unit,
// holds operands, stalls the front of the pipeline and presents the result for one cycle.
module multdiv_controller #(
    parameter int WIDTH      = 32,
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      dx_ir,
    input  logic [WIDTH-1:0] dx_A,
    input  logic [WIDTH-1:0] dx_B,
    input  logic [WIDTH-1:0] md_result,
    input  logic             md_exception,
    input  logic             md_resultRDY,
    output logic             md_ctrl_mult,
    output logic             md_ctrl_div,
    output logic [WIDTH-1:0] md_operandA,
    output logic [WIDTH-1:0] md_operandB,
    output logic             stall,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic             exception
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;

    logic is_mul, is_div, is_md, timeout;
    logic unused_ir;

    // Decode is masked while reset is held so no start pulse can leak out during reset.
    assign is_mul    = !reset && (dx_ir[31:27] == 5'b00000) && (dx_ir[6:2] == ALU_MUL);
    assign is_div    = !reset && (dx_ir[31:27] == 5'b00000) && (dx_ir[6:2] == ALU_DIV);
    assign is_md     = is_mul || is_div;
    assign timeout   = (count_q == CNT_W'(MAX_CYCLES - 1));
    assign unused_ir = ^{dx_ir[26:7], dx_ir[1:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (is_md) state_d = S_WAIT;
            S_WAIT:  if (md_resultRDY || timeout) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        exc_d    = exc_q;
        case (state_q)
            S_IDLE: begin
                if (is_md) begin
                    op_a_d  = dx_A;
                    op_b_d  = dx_B;
                    count_d = '0;
                end
            end
            S_WAIT: begin
                count_d = count_q + CNT_W'(1);
                // A ready strobe on the timeout cycle still delivers the real result.
                if (md_resultRDY) begin
                    result_d = md_result;
                    exc_d    = md_exception;
                end else if (timeout) begin
                    result_d = '0;
                    exc_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        md_ctrl_mult = 1'b0;
        md_ctrl_div  = 1'b0;
        md_operandA  = op_a_q;
        md_operandB  = op_b_q;
        stall        = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall        = is_md;
                md_ctrl_mult = is_mul;
                md_ctrl_div  = is_div;
                if (is_md) begin
                    md_operandA = dx_A;
                    md_operandB = dx_B;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                busy  = 1'b1;
            end
            S_DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign result    = result_q;
    assign exception = exc_q;

endmodule
